// File: rtl/stack_pointer_unit.sv
// Stack/frame pointer unit: push, pop, adjust, enter and leave with stack-window
// range checks, sticky faults and a registered data-memory port for stack accesses.
module stack_pointer_unit #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      WORD_BYTES  = 4,
   parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(32'h0000_1000),
   parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h0000_0000)
) (
   input  logic             clock_5,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   output logic             op_ready,
   input  logic [WIDTH-1:0] alu_result_bus,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] esp,
   output logic [WIDTH-1:0] ebp,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_we,
   output logic             mem_re,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             fault_ovf,
   output logic             fault_unf,
   input  logic             fault_clear
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_PUSH  = 3'd2,
      OP_POP   = 3'd3,
      OP_ADJ   = 3'd4,
      OP_ENTER = 3'd5,
      OP_LEAVE = 3'd6,
      OP_LDFP  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ENT2 = 2'd1,
      ST_LEV2 = 2'd2
   } state_e;

   state_e state;

   // Window checks done as borrow-out subtractions so they stay generic in WIDTH.
   function automatic logic below_limit(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] d;
      d = {1'b0, v} - {1'b0, STACK_LIMIT};
      return d[WIDTH];
   endfunction

   function automatic logic above_base(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] d;
      d = {1'b0, STACK_BASE} - {1'b0, v};
      return d[WIDTH];
   endfunction

   logic [WIDTH:0]   push_w;
   logic [WIDTH:0]   pop_w;
   logic [WIDTH:0]   leave_w;
   logic [WIDTH-1:0] push_n;
   logic [WIDTH-1:0] pop_n;
   logic [WIDTH-1:0] adj_n;
   logic             push_fault;
   logic             pop_fault;
   logic             leave_fault;
   logic             adj_low;
   logic             adj_high;
   logic             accept;
   logic             set_ovf;
   logic             set_unf;

   // Candidate pointers; the MSB of each widened result is the wrap indicator.
   always_comb begin
      push_w      = {1'b0, esp} - {1'b0, STEP};
      pop_w       = {1'b0, esp} + {1'b0, STEP};
      leave_w     = {1'b0, ebp} + {1'b0, STEP};
      push_n      = push_w[WIDTH-1:0];
      pop_n       = pop_w[WIDTH-1:0];
      adj_n       = esp + imm;
      push_fault  = push_w[WIDTH] | below_limit(push_n);
      pop_fault   = pop_w[WIDTH] | above_base(pop_n);
      leave_fault = leave_w[WIDTH] | above_base(leave_w[WIDTH-1:0]);
      adj_low     = below_limit(adj_n);
      adj_high    = above_base(adj_n);
   end

   assign accept = op_valid && (state == ST_IDLE);

   // Fault set terms for the op accepted this cycle.
   always_comb begin
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (accept) begin
         case (op_e'(op_code))
            OP_PUSH,
            OP_ENTER: set_ovf = push_fault;
            OP_POP:   set_unf = pop_fault;
            OP_LEAVE: set_unf = leave_fault;
            OP_ADJ: begin
               set_ovf = adj_low;
               set_unf = adj_high;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_5 or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         op_ready  <= 1'b1;
         esp       <= STACK_BASE;
         ebp       <= STACK_BASE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         fault_ovf <= 1'b0;
         fault_unf <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         // A new fault on the same edge as fault_clear keeps the flag set.
         fault_ovf <= set_ovf | (fault_ovf & ~fault_clear);
         fault_unf <= set_unf | (fault_unf & ~fault_clear);
         case (state)
            ST_ENT2: begin
               ebp      <= esp;
               state    <= ST_IDLE;
               op_ready <= 1'b1;
            end
            ST_LEV2: begin
               ebp      <= mem_rdata;
               esp      <= esp + STEP;
               state    <= ST_IDLE;
               op_ready <= 1'b1;
            end
            default: begin
               if (op_valid) begin
                  case (op_e'(op_code))
                     OP_LOAD: esp <= alu_result_bus;
                     OP_LDFP: ebp <= alu_result_bus;
                     OP_PUSH: begin
                        if (!push_fault) begin
                           esp       <= push_n;
                           mem_addr  <= push_n;
                           mem_wdata <= alu_result_bus;
                           mem_we    <= 1'b1;
                        end
                     end
                     OP_ENTER: begin
                        if (!push_fault) begin
                           esp       <= push_n;
                           mem_addr  <= push_n;
                           mem_wdata <= ebp;
                           mem_we    <= 1'b1;
                           state     <= ST_ENT2;
                           op_ready  <= 1'b0;
                        end
                     end
                     OP_POP: begin
                        if (!pop_fault) begin
                           esp      <= pop_n;
                           mem_addr <= esp;
                           mem_re   <= 1'b1;
                        end
                     end
                     OP_ADJ: begin
                        if (!adj_low && !adj_high) begin
                           esp <= adj_n;
                        end
                     end
                     OP_LEAVE: begin
                        // esp is re-based on ebp now; the saved frame is popped in LEV2.
                        if (!leave_fault) begin
                           esp      <= ebp;
                           mem_addr <= ebp;
                           mem_re   <= 1'b1;
                           state    <= ST_LEV2;
                           op_ready <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: directed vector table plus randomized ops checked
// against a wide-integer reference model, on two instances (default and raised limit).
module tb_stack_pointer_unit;

   localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, PUSH = 3'd2, POP = 3'd3,
                          ADJ = 3'd4, ENTER = 3'd5, LEAVE = 3'd6, LDFP = 3'd7;
   localparam longint unsigned BASE = 64'h1000;
   localparam longint unsigned MASK = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] alu_result_bus;
   logic [31:0] imm;
   logic [31:0] mem_rdata;
   logic        fault_clear;

   logic [31:0] esp_o[2], ebp_o[2], addr_o[2], wdata_o[2];
   logic        rdy_o[2], we_o[2], re_o[2], ovf_o[2], unf_o[2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   stack_pointer_unit dut0 (
      .clock_5(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_ready(rdy_o[0]), .alu_result_bus(alu_result_bus), .imm(imm),
      .esp(esp_o[0]), .ebp(ebp_o[0]), .mem_addr(addr_o[0]), .mem_we(we_o[0]),
      .mem_re(re_o[0]), .mem_wdata(wdata_o[0]), .mem_rdata(mem_rdata),
      .fault_ovf(ovf_o[0]), .fault_unf(unf_o[0]), .fault_clear(fault_clear)
   );

   stack_pointer_unit #(.STACK_LIMIT(32'h0000_0FF8)) dut1 (
      .clock_5(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_ready(rdy_o[1]), .alu_result_bus(alu_result_bus), .imm(imm),
      .esp(esp_o[1]), .ebp(ebp_o[1]), .mem_addr(addr_o[1]), .mem_we(we_o[1]),
      .mem_re(re_o[1]), .mem_wdata(wdata_o[1]), .mem_rdata(mem_rdata),
      .fault_ovf(ovf_o[1]), .fault_unf(unf_o[1]), .fault_clear(fault_clear)
   );

   // Reference model: pointers held as 64-bit integers so wrap shows up as out-of-window.
   longint unsigned m_esp[2], m_ebp[2], m_addr[2], m_wdata[2];
   bit              m_we[2], m_re[2], m_ovf[2], m_unf[2];
   int              m_phase[2];   // 0 idle, 1 finishing ENTER, 2 finishing LEAVE

   task automatic model_step(input int k);
      longint unsigned e, b, n, lo;
      bit so, su;
      lo = (k == 0) ? 64'h0 : 64'hFF8;
      e = m_esp[k];
      b = m_ebp[k];
      so = 1'b0;
      su = 1'b0;
      m_we[k] = 1'b0;
      m_re[k] = 1'b0;
      if (!reset) begin
         m_esp[k] = BASE; m_ebp[k] = BASE; m_addr[k] = 0; m_wdata[k] = 0;
         m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_phase[k] = 0;
         return;
      end
      if (m_phase[k] == 1) begin
         m_ebp[k] = e;
         m_phase[k] = 0;
      end else if (m_phase[k] == 2) begin
         m_ebp[k] = 64'(mem_rdata);
         m_esp[k] = (e + 4) & MASK;
         m_phase[k] = 0;
      end else if (op_valid) begin
         case (op_code)
            LOAD: m_esp[k] = 64'(alu_result_bus);
            LDFP: m_ebp[k] = 64'(alu_result_bus);
            PUSH, ENTER: begin
               if (e < 4 || e - 4 < lo) so = 1'b1;
               else begin
                  m_esp[k] = e - 4;
                  m_addr[k] = e - 4;
                  m_wdata[k] = (op_code == PUSH) ? 64'(alu_result_bus) : b;
                  m_we[k] = 1'b1;
                  if (op_code == ENTER) m_phase[k] = 1;
               end
            end
            POP: begin
               if (e + 4 > BASE) su = 1'b1;
               else begin
                  m_addr[k] = e;
                  m_re[k] = 1'b1;
                  m_esp[k] = e + 4;
               end
            end
            ADJ: begin
               n = (e + 64'(imm)) & MASK;
               if (n < lo) so = 1'b1;
               else if (n > BASE) su = 1'b1;
               else m_esp[k] = n;
            end
            LEAVE: begin
               if (b + 4 > BASE) su = 1'b1;
               else begin
                  m_esp[k] = b;
                  m_addr[k] = b;
                  m_re[k] = 1'b1;
                  m_phase[k] = 2;
               end
            end
            default: ;
         endcase
      end
      m_ovf[k] = (m_ovf[k] && !fault_clear) || so;
      m_unf[k] = (m_unf[k] && !fault_clear) || su;
   endtask

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
      end
   endtask

   // One clock: advance the model with the applied inputs, then compare both instances.
   task automatic cycle();
      for (int k = 0; k < 2; k++) model_step(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("m_esp", k, esp_o[k], 32'(m_esp[k]));
         chk("m_ebp", k, ebp_o[k], 32'(m_ebp[k]));
         chk("m_addr", k, addr_o[k], 32'(m_addr[k]));
         chk("m_wdata", k, wdata_o[k], 32'(m_wdata[k]));
         chk("m_we", k, 32'(we_o[k]), 32'(m_we[k]));
         chk("m_re", k, 32'(re_o[k]), 32'(m_re[k]));
         chk("m_ovf", k, 32'(ovf_o[k]), 32'(m_ovf[k]));
         chk("m_unf", k, 32'(unf_o[k]), 32'(m_unf[k]));
         chk("m_rdy", k, 32'(rdy_o[k]), 32'(m_phase[k] == 0));
      end
   endtask

   typedef struct {
      bit        rst_n;
      bit        v;
      bit [2:0]  op;
      bit [31:0] bus;
      bit [31:0] imm;
      bit [31:0] rdata;
      bit        clr;
      int        inst;
      bit [31:0] e_esp, e_ebp, e_addr, e_wdata;
      bit        e_we, e_re, e_ovf, e_unf, e_rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit v, input bit [2:0] op, input bit [31:0] bus,
                      input bit [31:0] im, input bit [31:0] rd, input bit clr, input int inst,
                      input bit [31:0] es, input bit [31:0] eb, input bit [31:0] ad,
                      input bit [31:0] wd, input bit we, input bit re, input bit ov,
                      input bit un, input bit rdy);
      vec_t t;
      t.rst_n = r; t.v = v; t.op = op; t.bus = bus; t.imm = im; t.rdata = rd; t.clr = clr;
      t.inst = inst; t.e_esp = es; t.e_ebp = eb; t.e_addr = ad; t.e_wdata = wd;
      t.e_we = we; t.e_re = re; t.e_ovf = ov; t.e_unf = un; t.e_rdy = rdy;
      vecs.push_back(t);
   endtask

   initial begin
      reset = 1'b0; op_valid = 1'b0; op_code = NOP; alu_result_bus = '0;
      imm = '0; mem_rdata = '0; fault_clear = 1'b0;

      //  rst v op     bus       imm          rdata    clr inst  esp     ebp     addr    wdata   we re ov un rdy
      add(0, 0, NOP,   0,        0,           0,       0, 0,    'h1000, 'h1000, 0,      0,      0, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h11,     0,           0,       0, 0,    'hFFC,  'h1000, 'hFFC,  'h11,   1, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h22,     0,           0,       0, 0,    'hFF8,  'h1000, 'hFF8,  'h22,   1, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h33,     0,           0,       0, 0,    'hFF4,  'h1000, 'hFF4,  'h33,   1, 0, 0, 0, 1);
      add(1, 1, POP,   0,        0,           0,       0, 0,    'hFF8,  'h1000, 'hFF4,  'h33,   0, 1, 0, 0, 1);
      add(1, 1, POP,   0,        0,           0,       0, 0,    'hFFC,  'h1000, 'hFF8,  'h33,   0, 1, 0, 0, 1);
      add(1, 1, POP,   0,        0,           0,       0, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 1, 0, 0, 1);
      add(1, 1, POP,   0,        0,           0,       0, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 0, 0, 1, 1);
      add(1, 0, NOP,   0,        0,           0,       1, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, POP,   0,        0,           0,       1, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 0, 0, 1, 1);
      add(1, 0, NOP,   0,        0,           0,       1, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, ADJ,   0,        'hFFFF_FFF0, 0,       0, 0,    'hFF0,  'h1000, 'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, ADJ,   0,        'h20,        0,       0, 0,    'hFF0,  'h1000, 'hFFC,  'h33,   0, 0, 0, 1, 1);
      add(1, 0, NOP,   0,        0,           0,       1, 0,    'hFF0,  'h1000, 'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, LOAD,  'h1000,   0,           0,       0, 0,    'h1000, 'h1000, 'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, LDFP,  'hABC,    0,           0,       0, 0,    'h1000, 'hABC,  'hFFC,  'h33,   0, 0, 0, 0, 1);
      add(1, 1, ENTER, 0,        0,           0,       0, 0,    'hFFC,  'hABC,  'hFFC,  'hABC,  1, 0, 0, 0, 0);
      add(1, 1, PUSH,  'h77,     0,           0,       0, 0,    'hFFC,  'hFFC,  'hFFC,  'hABC,  0, 0, 0, 0, 1);
      add(1, 1, LEAVE, 0,        0,           0,       0, 0,    'hFFC,  'hFFC,  'hFFC,  'hABC,  0, 1, 0, 0, 0);
      add(1, 0, NOP,   0,        0,           'hABC,   0, 0,    'h1000, 'hABC,  'hFFC,  'hABC,  0, 0, 0, 0, 1);
      add(1, 1, ENTER, 0,        0,           0,       0, 0,    'hFFC,  'hABC,  'hFFC,  'hABC,  1, 0, 0, 0, 0);
      add(0, 0, NOP,   0,        0,           0,       0, 0,    'h1000, 'h1000, 0,      0,      0, 0, 0, 0, 1);
      add(1, 0, NOP,   0,        0,           0,       0, 0,    'h1000, 'h1000, 0,      0,      0, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h1,      0,           0,       0, 1,    'hFFC,  'h1000, 'hFFC,  'h1,    1, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h2,      0,           0,       0, 1,    'hFF8,  'h1000, 'hFF8,  'h2,    1, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h3,      0,           0,       0, 1,    'hFF8,  'h1000, 'hFF8,  'h2,    0, 0, 1, 0, 1);
      add(1, 1, LOAD,  'h4,      0,           0,       0, 0,    'h4,    'h1000, 'hFF4,  'h3,    0, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h9,      0,           0,       0, 0,    'h0,    'h1000, 'h0,    'h9,    1, 0, 0, 0, 1);
      add(1, 1, PUSH,  'h8,      0,           0,       0, 0,    'h0,    'h1000, 'h0,    'h9,    0, 0, 1, 0, 1);
      add(1, 0, NOP,   0,        0,           0,       1, 0,    'h0,    'h1000, 'h0,    'h9,    0, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         int k;
         reset = vecs[i].rst_n; op_valid = vecs[i].v; op_code = vecs[i].op;
         alu_result_bus = vecs[i].bus; imm = vecs[i].imm; mem_rdata = vecs[i].rdata;
         fault_clear = vecs[i].clr;
         cycle();
         k = vecs[i].inst;
         chk($sformatf("v%0d_esp", i), k, esp_o[k], vecs[i].e_esp);
         chk($sformatf("v%0d_ebp", i), k, ebp_o[k], vecs[i].e_ebp);
         chk($sformatf("v%0d_addr", i), k, addr_o[k], vecs[i].e_addr);
         chk($sformatf("v%0d_wdata", i), k, wdata_o[k], vecs[i].e_wdata);
         chk($sformatf("v%0d_we", i), k, 32'(we_o[k]), 32'(vecs[i].e_we));
         chk($sformatf("v%0d_re", i), k, 32'(re_o[k]), 32'(vecs[i].e_re));
         chk($sformatf("v%0d_ovf", i), k, 32'(ovf_o[k]), 32'(vecs[i].e_ovf));
         chk($sformatf("v%0d_unf", i), k, 32'(unf_o[k]), 32'(vecs[i].e_unf));
         chk($sformatf("v%0d_rdy", i), k, 32'(rdy_o[k]), 32'(vecs[i].e_rdy));
      end

      // Randomized ops biased toward the stack window edges.
      for (int i = 0; i < 600; i++) begin
         int sel;
         reset = ($urandom_range(0, 63) != 0);
         op_valid = ($urandom_range(0, 7) != 0);
         op_code = 3'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 3));
         if (sel == 0) alu_result_bus = $urandom;
         else if (sel == 1) alu_result_bus = 32'($urandom_range(0, 12));
         else alu_result_bus = 32'h1000 - 32'($urandom_range(0, 40));
         imm = 32'($urandom_range(0, 80)) - 32'd40;
         mem_rdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'h1000 - 32'($urandom_range(0, 16));
         fault_clear = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
